// File: rtl/shift_pkg.sv
// Shift-unit opcodes shared by the barrel shifter and the instruction decoder.
package shift_pkg;

  typedef enum logic [2:0] {
    SH_LSL = 3'd0,
    SH_LSR = 3'd1,
    SH_ASR = 3'd2,
    SH_ROL = 3'd3,
    SH_ROR = 3'd4
  } shift_op_e;

  localparam int OP_W = 3;

endpackage

// File: rtl/barrel_shift_stage.sv
// One log2 step of the barrel shifter: shifts by SHIFT when amt[K] is set and
// registers {valid, d, amt, op, carry} behind a skid-free valid/ready stage.
module barrel_shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5,
  parameter int K     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_ready,
  input  logic [WIDTH-1:0] i_d,
  input  logic [SHW-1:0]   i_amt,
  input  logic [OP_W-1:0]  i_op,
  input  logic             i_carry,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_d,
  output logic [SHW-1:0]   o_amt,
  output logic [OP_W-1:0]  o_op,
  output logic             o_carry
);

  localparam int SHIFT = 2 ** K;

  logic [WIDTH-1:0] w_d;
  logic             w_carry;
  logic             r_valid;
  logic [WIDTH-1:0] r_d;
  logic [SHW-1:0]   r_amt;
  logic [OP_W-1:0]  r_op;
  logic             r_carry;

  always_comb begin
    w_d     = i_d;
    w_carry = i_carry;
    if (i_amt[K]) begin
      case (i_op)
        SH_LSL: begin
          w_d     = i_d << SHIFT;
          w_carry = i_d[WIDTH-SHIFT];
        end
        SH_LSR: begin
          w_d     = i_d >> SHIFT;
          w_carry = i_d[SHIFT-1];
        end
        SH_ASR: begin
          w_d     = $signed(i_d) >>> SHIFT;
          w_carry = i_d[SHIFT-1];
        end
        SH_ROL:  w_d = {i_d[WIDTH-SHIFT-1:0], i_d[WIDTH-1:WIDTH-SHIFT]};
        SH_ROR:  w_d = {i_d[SHIFT-1:0], i_d[WIDTH-1:SHIFT]};
        default: ;
      endcase
    end
    // Rotate carry tracks the current result so the final stage leaves the right bit.
    if (i_amt != '0) begin
      if (i_op == SH_ROL) w_carry = w_d[0];
      if (i_op == SH_ROR) w_carry = w_d[WIDTH-1];
    end
  end

  assign o_ready = ~r_valid | i_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_d     <= '0;
      r_amt   <= '0;
      r_op    <= '0;
      r_carry <= 1'b0;
    end else if (o_ready) begin
      r_valid <= i_valid;
      r_d     <= w_d;
      r_amt   <= i_amt;
      r_op    <= i_op;
      r_carry <= w_carry;
    end
  end

  assign o_valid = r_valid;
  assign o_d     = r_d;
  assign o_amt   = r_amt;
  assign o_op    = r_op;
  assign o_carry = r_carry;

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter (LSL/LSR/ASR/ROL/ROR) with one register stage per
// shift-amount bit, valid/ready on both sides, carry-out and zero flags.
module barrel_shifter_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_d,
  input  logic [SHW-1:0]   in_amt,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_q,
  output logic             out_carry,
  output logic             out_zero
);

  logic             w_valid [SHW+1];
  logic             w_ready [SHW+1];
  logic [WIDTH-1:0] w_d     [SHW+1];
  logic [SHW-1:0]   w_amt   [SHW+1];
  logic [OP_W-1:0]  w_op    [SHW+1];
  logic             w_carry [SHW+1];
  logic             w_unused;

  assign w_valid[0] = in_valid;
  assign w_d[0]     = in_d;
  assign w_amt[0]   = in_amt;
  assign w_op[0]    = in_op;
  assign w_carry[0] = 1'b0;

  for (genvar gi = 0; gi < SHW; gi++) begin : g_stage
    barrel_shift_stage #(
      .WIDTH(WIDTH),
      .SHW  (SHW),
      .K    (gi)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .i_valid(w_valid[gi]),
      .o_ready(w_ready[gi]),
      .i_ready(w_ready[gi+1]),
      .i_d    (w_d[gi]),
      .i_amt  (w_amt[gi]),
      .i_op   (w_op[gi]),
      .i_carry(w_carry[gi]),
      .o_valid(w_valid[gi+1]),
      .o_d    (w_d[gi+1]),
      .o_amt  (w_amt[gi+1]),
      .o_op   (w_op[gi+1]),
      .o_carry(w_carry[gi+1])
    );
  end

  // The last stage register is the output register, giving exactly SHW cycles of latency.
  assign w_ready[SHW] = ~w_valid[SHW] | out_ready;
  assign in_ready     = w_ready[0];

  assign out_valid = w_valid[SHW];
  assign out_q     = w_d[SHW];
  assign out_carry = w_carry[SHW];
  assign out_zero  = w_valid[SHW] & (w_d[SHW] == '0);

  assign w_unused = ^{w_amt[SHW], w_op[SHW]};

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Self-checking bench for barrel_shifter_pipe: vector table, random stream with
// back-pressure, and hand sequences for latency, stall and mid-flight reset.
module tb_barrel_shifter_pipe;

  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_d = '0;
  logic [SHW-1:0]   in_amt = '0;
  logic [2:0]       in_op = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_q;
  logic             out_carry;
  logic             out_zero;

  barrel_shifter_pipe #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_d     (in_d),
    .in_amt   (in_amt),
    .in_op    (in_op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_q    (out_q),
    .out_carry(out_carry),
    .out_zero (out_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] d;
    logic [4:0]  amt;
    logic [31:0] q;
    logic        c;
    logic        z;
  } vec_t;

  typedef struct {
    logic [31:0] q;
    logic        c;
    logic        z;
    int          id;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_acc = 0;
  int          next_id = 0;
  logic [33:0] held;
  bit          held_v = 0;
  bit          rnd_done;
  vec_t        tbl[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic logic [33:0] model(input logic [2:0] op, input logic [31:0] d,
                                        input logic [4:0] amt);
    logic [31:0] q;
    logic        c;
    q = d;
    c = 1'b0;
    if (amt != 0) begin
      case (op)
        3'd0: begin q = d << amt; c = d[32-amt]; end
        3'd1: begin q = d >> amt; c = d[amt-1]; end
        3'd2: begin q = $signed(d) >>> amt; c = d[amt-1]; end
        3'd3: begin q = (d << amt) | (d >> (32 - amt)); c = q[0]; end
        3'd4: begin q = (d >> amt) | (d << (32 - amt)); c = q[31]; end
        default: ;
      endcase
    end
    return {q, c, (q == 32'd0)};
  endfunction

  // Scoreboard consumer: one comparison per delivered beat, plus hold checks while stalled.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_beat: got q=%h with no beat outstanding", out_q);
        end else begin
          exp_t e;
          e = sb.pop_front();
          $display("beat %0d: q=%h c=%b z=%b (want %h %b %b)", e.id, out_q, out_carry,
                   out_zero, e.q, e.c, e.z);
          check($sformatf("beat%0d", e.id), {30'd0, out_q, out_carry, out_zero},
                {30'd0, e.q, e.c, e.z});
        end
        held_v = 0;
      end else begin
        if (held_v) check("stall_hold", {30'd0, out_q, out_carry, out_zero}, {30'd0, held});
        held   = {out_q, out_carry, out_zero};
        held_v = 1;
      end
    end else begin
      held_v = 0;
    end
  end

  // Call at posedge+#1; returns at posedge+#1 after the beat is accepted.
  task automatic send(input logic [2:0] op, input logic [31:0] d, input logic [4:0] amt,
                      input logic [31:0] q, input logic c, input logic z);
    int    w;
    exp_t  e;
    w        = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_d     = d;
    in_amt   = amt;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
    end else begin
      e.q = q; e.c = c; e.z = z; e.id = next_id;
      next_id++;
      sb.push_back(e);
      n_acc++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 300) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  // Idle pipeline: count edges from the accept edge until out_valid appears.
  task automatic latency_beat(input logic [2:0] op, input logic [31:0] d, input logic [4:0] amt,
                              input logic [31:0] q, input logic c, input logic z);
    int   n;
    exp_t e;
    in_valid = 1'b1;
    in_op    = op;
    in_d     = d;
    in_amt   = amt;
    @(negedge clk);
    check("lat_in_ready", 64'(in_ready), 64'd1);
    e.q = q; e.c = c; e.z = z; e.id = next_id;
    next_id++;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", 64'(n), 64'(SHW));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d beats outstanding", sb.size());
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{3'd0, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 1'b0};
    tbl[1]  = '{3'd2, 32'h8000_00F0, 5'd5,  32'hFC00_0007, 1'b1, 1'b0};
    tbl[2]  = '{3'd1, 32'h0000_0001, 5'd1,  32'h0000_0000, 1'b1, 1'b1};
    tbl[3]  = '{3'd4, 32'h0000_0001, 5'd1,  32'h8000_0000, 1'b1, 1'b0};
    tbl[4]  = '{3'd3, 32'h8000_0000, 5'd1,  32'h0000_0001, 1'b1, 1'b0};
    tbl[5]  = '{3'd3, 32'h1234_5678, 5'd8,  32'h3456_7812, 1'b0, 1'b0};
    tbl[6]  = '{3'd0, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0, 1'b0};
    tbl[7]  = '{3'd1, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0, 1'b0};
    tbl[8]  = '{3'd2, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0, 1'b0};
    tbl[9]  = '{3'd3, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0, 1'b0};
    tbl[10] = '{3'd4, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0, 1'b0};
    tbl[11] = '{3'd7, 32'hDEAD_BEEF, 5'd9,  32'hDEAD_BEEF, 1'b0, 1'b0};
    tbl[12] = '{3'd5, 32'h0000_0000, 5'd31, 32'h0000_0000, 1'b0, 1'b1};
    tbl[13] = '{3'd0, 32'hF000_0000, 5'd4,  32'h0000_0000, 1'b1, 1'b1};
    tbl[14] = '{3'd4, 32'h1234_5678, 5'd31, 32'h2468_ACF0, 1'b0, 1'b0};
    tbl[15] = '{3'd1, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_q", 64'(out_q), 64'd0);
    check("rst_flags", {62'd0, out_carry, out_zero}, 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Latency on an idle pipeline
    latency_beat(3'd0, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 1'b0);
    drain();

    // Vector table, back-to-back
    for (int i = 0; i < 16; i++)
      send(tbl[i].op, tbl[i].d, tbl[i].amt, tbl[i].q, tbl[i].c, tbl[i].z);
    drain();

    // Random stream against the model with random back-pressure
    rnd_done = 0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          logic [2:0]  op;
          logic [31:0] d;
          logic [4:0]  amt;
          logic [33:0] r;
          op  = 3'($urandom_range(0, 7));
          d   = $urandom;
          amt = 5'($urandom_range(0, 31));
          if (i % 7 == 0) d = 32'd0;
          r = model(op, d, amt);
          send(op, d, amt, r[33:2], r[1], r[0]);
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Back-pressure: 10 beats, out_ready low during cycles 3..9
    n_acc = 0;
    fork
      begin
        for (int i = 0; i < 10; i++)
          send(3'd0, 32'(i), 5'd1, 32'(2 * i), 1'b0, (i == 0));
      end
      begin
        out_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        out_ready = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        @(negedge clk);
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        check("bp_beats_held", 64'(n_acc), 64'(SHW));
        repeat (2) begin @(posedge clk); #1; end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with beats in flight: one held at the output, none may survive
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(3'd1, 32'h100 << i, 5'd4, 32'h10 << i, 1'b0, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    check("pre_rst_out_valid", 64'(out_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_now_out_valid", 64'(out_valid), 64'd0);
    check("rst_now_out_q", 64'(out_q), 64'd0);
    check("rst_now_in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    latency_beat(3'd2, 32'hF000_000F, 5'd2, 32'hFC00_0003, 1'b1, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
